// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: instruction handshake, EXEC/MEM sequencing with a RAM
// timeout, sticky halt/illegal/bus-error flags. Define BIP_BRANCH_EN to enable BEQZ and JMP.
module bip_control_unit #(
  parameter int OPCODE_W    = 5,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_rdy,
  input  logic                acc_zero,
  output logic                wr_pc,
  output logic                sel_pc,
  output logic [1:0]          sel_a,
  output logic                sel_b,
  output logic                wr_acc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                wr_ram,
  output logic                rd_ram,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [2:0] {K_HLT, K_MEM, K_IMM, K_JMP, K_BEQZ, K_ILL} kind_t;

  typedef struct packed {
    kind_t               kind;
    logic                is_sto;
    logic                is_ld;
    logic                is_ldi;
    logic [ALU_OP_W-1:0] alu;
  } dec_t;

  state_t           state, next_state;
  logic [OPCODE_W-1:0] ir;
  logic [CNT_W-1:0] tmo_cnt;
  logic             accept;
  logic             mem_timeout;
  dec_t             dec_in, dec_ir;

  // Opcodes with any bit set above [4:0] fall through to K_ILL.
  function automatic dec_t decode(input logic [OPCODE_W-1:0] op);
    dec_t d;
    d.kind   = K_ILL;
    d.is_sto = 1'b0;
    d.is_ld  = 1'b0;
    d.is_ldi = 1'b0;
    d.alu    = ALU_SUB;
    if ((op >> 5) == '0) begin
      case (op[4:0])
        5'd0:  d.kind = K_HLT;
        5'd1:  begin d.kind = K_MEM; d.is_sto = 1'b1; end
        5'd2:  begin d.kind = K_MEM; d.is_ld  = 1'b1; end
        5'd3:  begin d.kind = K_IMM; d.is_ldi = 1'b1; end
        5'd4:  begin d.kind = K_MEM; d.alu = ALU_ADD; end
        5'd5:  begin d.kind = K_IMM; d.alu = ALU_ADD; end
        5'd6:  begin d.kind = K_MEM; d.alu = ALU_SUB; end
        5'd7:  begin d.kind = K_IMM; d.alu = ALU_SUB; end
        5'd8:  begin d.kind = K_MEM; d.alu = ALU_AND; end
        5'd9:  begin d.kind = K_IMM; d.alu = ALU_AND; end
        5'd10: begin d.kind = K_MEM; d.alu = ALU_OR;  end
        5'd11: begin d.kind = K_IMM; d.alu = ALU_OR;  end
        5'd12: begin d.kind = K_MEM; d.alu = ALU_XOR; end
        5'd13: begin d.kind = K_IMM; d.alu = ALU_XOR; end
`ifdef BIP_BRANCH_EN
        5'd14: d.kind = K_BEQZ;
        5'd15: d.kind = K_JMP;
`endif
        default: d.kind = K_ILL;
      endcase
    end
    return d;
  endfunction

  assign dec_in = decode(opcode);
  assign dec_ir = decode(ir);
  assign accept = (state == S_IDLE) && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir      <= '0;
      tmo_cnt <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        ir <= opcode;
        if (dec_in.kind == K_ILL) illegal <= 1'b1;
      end
      if (state == S_MEM && !mem_rdy) tmo_cnt <= tmo_cnt + 1'b1;
      else                            tmo_cnt <= '0;
      if (mem_timeout) bus_err <= 1'b1;
    end
  end

  // Strobes are decoded from IR; MEM completion strobes follow mem_rdy combinationally.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    wr_pc       = 1'b0;
    sel_pc      = 1'b0;
    sel_a       = 2'b11;
    sel_b       = 1'b0;
    wr_acc      = 1'b0;
    alu_op      = '0;
    wr_ram      = 1'b0;
    rd_ram      = 1'b0;
    halted      = 1'b0;
    mem_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (dec_in.kind)
            K_HLT:   next_state = S_HALT;
            K_MEM:   next_state = S_MEM;
            default: next_state = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        next_state = S_IDLE;
        wr_pc      = 1'b1;
        case (dec_ir.kind)
          K_IMM: begin
            wr_acc = 1'b1;
            sel_b  = 1'b1;
            sel_a  = dec_ir.is_ldi ? 2'b01 : 2'b10;
            alu_op = dec_ir.alu;
          end
`ifdef BIP_BRANCH_EN
          K_JMP:  sel_pc = 1'b1;
          K_BEQZ: sel_pc = acc_zero;
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        alu_op = dec_ir.alu;
        if (dec_ir.is_sto) begin
          wr_ram = 1'b1;
        end else begin
          rd_ram = 1'b1;
          sel_a  = dec_ir.is_ld ? 2'b00 : 2'b10;
        end
        // A ready arriving on the last allowed cycle still completes normally.
        if (mem_rdy) begin
          wr_pc      = 1'b1;
          wr_acc     = !dec_ir.is_sto;
          next_state = S_IDLE;
        end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          mem_timeout = 1'b1;
          next_state  = S_HALT;
        end
      end
      S_HALT: halted = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

`ifndef BIP_BRANCH_EN
  logic unused_acc_zero;
  assign unused_acc_zero = acc_zero;
`endif

endmodule
